// File: rtl/snake_seq_ctrl_if.sv
// Control and display bundle for the snake animation controller.
// The master side drives the controls; the slave side (the controller) drives the display and status.
interface snake_seq_ctrl_if;
    logic       start;
    logic       pause;
    logic       stop;
    logic       dir;
    logic [1:0] speed;
    logic [7:0] out;
    logic [3:0] am;
    logic [3:0] head;
    logic [3:0] lap;
    logic       step_o;
    logic [1:0] state_o;

    modport master (
        output start, pause, stop, dir, speed,
        input  out, am, head, lap, step_o, state_o
    );

    modport slave (
        input  start, pause, stop, dir, speed,
        output out, am, head, lap, step_o, state_o
    );
endinterface

// File: rtl/snake_seq_ctrl.sv
// Runs a 3-segment snake around the outer perimeter of a 4-digit multiplexed 7-segment display.
// A prescaler sets the step rate, and a free-running scan counter multiplexes the digits.
module snake_seq_ctrl #(
    parameter int unsigned DIV_W  = 25,
    parameter int unsigned SCAN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    snake_seq_ctrl_if.slave  bus
);
    localparam int unsigned POS_N = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } state_t;

    state_t              state;
    logic [DIV_W-1:0]    presc;
    logic [DIV_W-1:0]    limit_m1;
    logic [SCAN_W-1:0]   scan;
    logic [3:0]          head;
    logic [3:0]          lap;
    logic [3:0]          head_nx;
    logic [7:0]          out_r;
    logic [3:0]          am_r;
    logic                step_c;
    logic                wrap_c;
    logic [POS_N-1:0]    lit_c;
    logic [1:0]          digit_c;
    logic [7:0]          seg_c;

    function automatic logic [3:0] inc12(input logic [3:0] p);
        return (p == 4'd11) ? 4'd0 : p + 4'd1;
    endfunction

    function automatic logic [3:0] dec12(input logic [3:0] p);
        return (p == 4'd0) ? 4'd11 : p - 4'd1;
    endfunction

    // 2^(DIV_W-speed)-1 is an all-ones word shifted right by speed
    assign limit_m1 = {DIV_W{1'b1}} >> bus.speed;
    assign step_c   = (state == RUN) && (presc >= limit_m1);
    assign digit_c  = scan[SCAN_W-1 -: 2];

    always_comb begin
        head_nx = bus.dir ? dec12(head) : inc12(head);
        wrap_c  = bus.dir ? (head == 4'd0) : (head == 4'd11);
    end

    // Tail side follows the live dir input so a reversal shows without waiting for a step
    always_comb begin
        lit_c = '0;
        if (state == IDLE) begin
            lit_c[0] = 1'b1;
        end else begin
            lit_c[head] = 1'b1;
            if (bus.dir) begin
                lit_c[inc12(head)]        = 1'b1;
                lit_c[inc12(inc12(head))] = 1'b1;
            end else begin
                lit_c[dec12(head)]        = 1'b1;
                lit_c[dec12(dec12(head))] = 1'b1;
            end
        end
    end

    // Perimeter position to {a,b,c,d,e,f,g,dp} of the digit being scanned
    always_comb begin
        seg_c = '0;
        case (digit_c)
            2'd0:    seg_c = {lit_c[3], lit_c[4], lit_c[5], lit_c[6], 4'b0000};
            2'd1:    seg_c = {lit_c[2], 2'b00, lit_c[7], 4'b0000};
            2'd2:    seg_c = {lit_c[1], 2'b00, lit_c[8], 4'b0000};
            default: seg_c = {lit_c[0], 2'b00, lit_c[9], lit_c[10], lit_c[11], 2'b00};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            presc <= '0;
            scan  <= '0;
            head  <= '0;
            lap   <= '0;
            out_r <= 8'h00;
            am_r  <= 4'b1110;
        end else begin
            scan  <= scan + SCAN_W'(1);
            out_r <= seg_c;
            am_r  <= ~(4'b0001 << digit_c);
            case (state)
                IDLE: begin
                    if (bus.start && !bus.stop && !bus.pause) begin
                        state <= RUN;
                    end
                end
                RUN, PAUSE: begin
                    if (bus.stop) begin
                        state <= IDLE;
                        presc <= '0;
                        head  <= '0;
                        lap   <= '0;
                    end else begin
                        // A pending step still lands on the edge that enters PAUSE
                        if (step_c) begin
                            presc <= '0;
                            head  <= head_nx;
                            if (wrap_c) begin
                                lap <= (lap == 4'd9) ? 4'd0 : lap + 4'd1;
                            end
                        end else if (state == RUN) begin
                            presc <= presc + DIV_W'(1);
                        end
                        state <= bus.pause ? PAUSE : RUN;
                    end
                end
                default: begin
                    state <= IDLE;
                    presc <= '0;
                    head  <= '0;
                    lap   <= '0;
                end
            endcase
        end
    end

    assign bus.out     = out_r;
    assign bus.am      = am_r;
    assign bus.head    = head;
    assign bus.lap     = lap;
    assign bus.step_o  = step_c;
    assign bus.state_o = state;
endmodule

// File: doc/snake_seq_ctrl.md
SNAKE_SEQ_CTRL -- requirements
Module: snake_seq_ctrl

Interface
REQ-001 Parameter: DIV_W, default 25, prescaler width; base step period is 2^DIV_W clk cycles.
REQ-002 Parameter: SCAN_W, default 16, digit-scan counter width.
REQ-003 Port: clk  input  1  sole clock; all logic on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: start  input  1  level; IDLE->RUN request.
REQ-006 Port: pause  input  1  level; hold animation while high.
REQ-007 Port: stop  input  1  level; return to IDLE.
REQ-008 Port: dir  input  1  0 = clockwise (head index +1), 1 = counter-clockwise (head index -1).
REQ-009 Port: speed  input  2  step period = 2^(DIV_W-speed) cycles.
REQ-010 Port: out  output  8  segment drive {a,b,c,d,e,f,g,dp}, 1 = lit, registered.
REQ-011 Port: am  output  4  digit enables, active-low, one-hot-low, registered.
REQ-012 Port: head  output  4  current head position, 0..11.
REQ-013 Port: lap  output  4  completed laps, BCD 0..9.
REQ-014 Port: step_o  output  1  one-cycle pulse on each head advance.
REQ-015 Port: state_o  output  2  00 IDLE, 01 RUN, 10 PAUSE.

Function
REQ-016 FSM states: IDLE, RUN, PAUSE; priority per cycle: stop > pause > start.
REQ-017 IDLE: start=1 and stop=0 and pause=0 -> RUN; otherwise stay IDLE.
REQ-018 RUN: stop -> IDLE; pause -> PAUSE; start ignored.
REQ-019 PAUSE: stop -> IDLE; pause=0 -> RUN; head, lap, prescaler frozen.
REQ-020 Entering IDLE (any source): head=0, lap=0, prescaler=0 on the same edge.
REQ-021 Prescaler is DIV_W bits; it counts only in RUN and holds in PAUSE.
REQ-022 step_o = (state==RUN) and (prescaler >= 2^(DIV_W-speed)-1), combinational from registers; on that edge prescaler clears to 0 and head advances.
REQ-023 Speed change mid-count: if prescaler already >= new limit-1, step occurs on the next RUN cycle.
REQ-024 Perimeter positions: 0-3 = segment a of digits 3,2,1,0; 4 = b of digit 0; 5 = c of digit 0; 6-9 = d of digits 0,1,2,3; 10 = e of digit 3; 11 = f of digit 3.
REQ-025 Head wraps modulo 12: 11->0 (dir=0), 0->11 (dir=1).
REQ-026 Each wrap increments lap; lap 9->0.
REQ-027 Snake length 3: lit positions = head, and head-1 and head-2 (dir=0) or head+1 and head+2 (dir=1), all modulo 12; a dir change moves the tail side immediately, without waiting for a step.
REQ-028 In IDLE, out shows only position 0 lit; PAUSE shows frozen snake; segments g and dp are never lit.
REQ-029 The scan counter is free-running in all states; digit index = top 2 bits; am bit k=0 when index==k; out = lit segments of digit k; out and am update on the same edge.
REQ-030 Counter widths wrap naturally; no other arithmetic saturates.

Reset
REQ-031 reset=1 on an edge: state=IDLE, prescaler=0, scan counter=0, head=0, lap=0; the following cycle shows out=0x00, am=4'b1110.
REQ-032 Reset overrides all inputs, including mid-step and in PAUSE.
REQ-033 After reset release, the block stays in IDLE until a start is accepted under REQ-017.

Verification (DIV_W=4, SCAN_W=2)
REQ-034 reset, start=1 for 1 cycle, speed=0, dir=0 -> state_o=01; step_o every 16 cycles; head 0,1,2..11,0; lap=1 after the 12th step.
REQ-035 RUN with speed=3 -> step_o every 2 cycles; switch to speed=0 mid-count -> next step 16 cycles after the last step.
REQ-036 RUN with head=5, pause=1 for 40 cycles -> state_o=10, head=5, no step_o; pause=0 -> remaining prescaler count resumes.
REQ-037 head=0, dir=1 -> next step head=11, lap+1; lit positions become 11,0,1 (was 0,11,10).
REQ-038 Assert stop, pause and start together in RUN -> IDLE next edge; head=0, lap=0; only position 0 lit.
REQ-039 Scan check: am cycles 1110,1101,1011,0111 every cycle; with head=2, dir=0 -> out=10000000 for digits 3,2,1 and 00000000 for digit 0.
